// File: rtl/tone_decoder_pkg.sv
// tone_decoder_pkg: note/octave constants shared with the tone generator, plus the period classifier.
package tone_decoder_pkg;
  localparam int NOTE_W = 4;
  localparam int OCT_W = 3;
  localparam int NUM_NOTES = 12;
  localparam int NUM_OCT = 6;
  localparam int OCT_LO = 263;
  localparam int OCT_HI = 526;
  localparam int CNT_W_DEF = 18;
  localparam int TIMEOUT_DEF = 134656;
  localparam logic [9:0] NOTE_DIV [NUM_NOTES] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};
  localparam logic [9:0] NOTE_THR [NUM_NOTES-1] = '{497, 469, 443, 418, 395, 373, 352, 332, 313, 295, 279};
  typedef struct packed {
    logic oor;
    logic [OCT_W-1:0] octave;
    logic [NOTE_W-1:0] note;
  } cls_t;
  localparam cls_t CLS_NONE = '{oor: 1'b1, octave: '0, note: '0};
  function automatic cls_t classify(input logic [31:0] p);
    cls_t c;
    logic [31:0] m;
    c = CLS_NONE;
    m = '0;
    for (int o = NUM_OCT-1; o >= 0; o--)
      if (p >= 32'(OCT_LO << (8-o)) && p < 32'(OCT_HI << (8-o))) begin
        c.oor = 1'b0;
        c.octave = OCT_W'(o);
        m = p >> (8-o);
      end
    c.note = NOTE_W'(NUM_NOTES-1);
    // Scanning downward leaves the first (highest) threshold met as the winner.
    for (int n = NUM_NOTES-2; n >= 0; n--)
      if (m >= 32'(NOTE_THR[n])) c.note = NOTE_W'(n);
    return c;
  endfunction
endpackage

// File: rtl/tone_decoder_period_meter.sv
// tone_decoder_period_meter: synchronizes the tone line, detects edges and measures half-periods.
// Defining TONE_DEC_DEBOUNCE_EN inserts a 4-sample glitch filter after the synchronizer.
module tone_decoder_period_meter #(
  parameter int CNT_W = 18,
  parameter int TIMEOUT = 134656
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic             o_cap,
  output logic             o_to,
  output logic [CNT_W-1:0] o_p
);
  logic [1:0] r_sync;
  logic r_lvl, r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic w_s, w_new, w_edge, w_hit;
  assign w_s = r_sync[1];
`ifdef TONE_DEC_DEBOUNCE_EN
  logic [2:0] r_hist;
  always_ff @(posedge clk)
    r_hist <= !rst_n ? '0 : {r_hist[1:0], w_s};
  assign w_new = (r_hist == {3{w_s}}) ? w_s : r_lvl;
`else
  assign w_new = w_s;
`endif
  assign w_edge = w_new != r_lvl;
  assign w_hit = r_cnt == CNT_W'(TIMEOUT);
  // A timeout wins over a coincident edge; that edge only re-arms.
  assign o_to = r_armed && w_hit;
  assign o_cap = r_armed && w_edge && !w_hit;
  assign o_p = r_cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_sync <= '0;
      r_lvl <= 1'b0;
      r_armed <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], tone_in};
      r_lvl <= w_new;
      r_armed <= w_edge || (r_armed && !w_hit);
      r_cnt <= w_edge ? CNT_W'(1) : (w_hit || &r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: decodes half-periods of a square-wave tone into (octave, note) with 2-period agreement.
// Optional glitch filter in the period meter is enabled by TONE_DEC_DEBOUNCE_EN.
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tone_in,
  output logic [NOTE_W-1:0] note,
  output logic [OCT_W-1:0]  octave,
  output logic              valid,
  output logic              strobe
);
  logic w_cap, w_to, w_hit, w_chg, w_drop;
  logic [CNT_W-1:0] w_p;
  logic r_cls_v;
  cls_t r_cls, r_cand;
  tone_decoder_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter (
    .clk(clk),
    .rst_n(rst_n),
    .tone_in(tone_in),
    .o_cap(w_cap),
    .o_to(w_to),
    .o_p(w_p)
  );
  // An empty candidate is encoded as out-of-range so it can never match.
  assign w_hit = !r_cls.oor && r_cls == r_cand;
  assign w_chg = !valid || r_cls.note != note || r_cls.octave != octave;
  assign w_drop = (r_cls_v && r_cls.oor) || w_to;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_cls_v <= 1'b0;
      r_cls <= '0;
      r_cand <= CLS_NONE;
      note <= '0;
      octave <= '0;
      valid <= 1'b0;
      strobe <= 1'b0;
    end else begin
      r_cls_v <= w_cap;
      if (w_cap) r_cls <= classify(32'(w_p));
      strobe <= 1'b0;
      if (w_to) r_cand <= CLS_NONE;
      else if (r_cls_v) r_cand <= r_cls;
      if (r_cls_v && w_hit && w_chg) begin
        note <= r_cls.note;
        octave <= r_cls.octave;
        valid <= 1'b1;
        strobe <= 1'b1;
      end else if (w_drop && valid) begin
        valid <= 1'b0;
        strobe <= 1'b1;
      end
    end
endmodule
